// File: rtl/diff_eq_filter_if.sv
// diff_eq_filter_if
// Sample, handshake and coefficient-load signals for diff_eq_filter.
//   master : sample source / controller (drives x, in_valid, control and coefficient writes)
//   slave  : the filter (drives in_ready, y, out_valid, ovf)
// Signals:
//   x, in_valid, in_ready      input sample with valid/ready handshake
//   y, out_valid, ovf          output sample, one-cycle strobe, overflow flag
//   sat_en, clear              saturate-vs-wrap select, history clear / abort
//   coef_we, coef_sel,         coefficient write strobe, bank (0 = b, 1 = a),
//   coef_addr, coef_data       tap index and signed value
interface diff_eq_filter_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COEF_W = 8
);
   logic signed [DATA_W-1:0] x;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] y;
   logic                     out_valid;
   logic                     ovf;
   logic                     sat_en;
   logic                     clear;
   logic                     coef_we;
   logic                     coef_sel;
   logic [2:0]               coef_addr;
   logic signed [COEF_W-1:0] coef_data;

   modport master (
      output x, in_valid, sat_en, clear, coef_we, coef_sel, coef_addr, coef_data,
      input  in_ready, y, out_valid, ovf
   );

   modport slave (
      input  x, in_valid, sat_en, clear, coef_we, coef_sel, coef_addr, coef_data,
      output in_ready, y, out_valid, ovf
   );
endinterface

// File: rtl/diff_eq_filter.sv
// diff_eq_filter
// Time-multiplexed constant-coefficient difference equation:
//   y[n] = sum(k=0..ORDER) b_k*x[n-k] + sum(k=1..ORDER) a_k*y[n-k]
// One multiply-accumulate per cycle, so one sample takes 2*ORDER+3 cycles.
// Coefficients are signed fixed point with COEF_FRAC fractional bits; the sum is
// rounded half-up, then saturated or wrapped to DATA_W. Reset coefficients
// (b_0 = a_1 = 1.0) give the plain accumulator y[n] = x[n] + y[n-1].
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    diff_eq_filter_if slave modport (sample handshake, output, control, coef load)
module diff_eq_filter #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned COEF_W    = 8,
   parameter int unsigned COEF_FRAC = 6,
   parameter int unsigned ORDER     = 2,
   parameter int unsigned ACC_W     = DATA_W + COEF_W + 4
) (
   input  logic            clk,
   input  logic            reset,
   diff_eq_filter_if.slave bus
);

   localparam int unsigned NumTaps = 2 * ORDER + 1;
   localparam int unsigned TapW    = $clog2(NumTaps);
   localparam int unsigned ProdW   = DATA_W + COEF_W;

   localparam logic signed [COEF_W-1:0] CoefOne   = COEF_W'(2 ** COEF_FRAC);
   localparam logic signed [ACC_W-1:0]  RoundHalf = ACC_W'(2 ** (COEF_FRAC - 1));
   localparam logic signed [ACC_W-1:0]  MaxVal    = ACC_W'(2 ** (DATA_W - 1) - 1);
   // ~(2^(N-1)-1) is -2^(N-1) in two's complement
   localparam logic signed [ACC_W-1:0]  MinVal    = ~MaxVal;

   typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

   state_e state_q, state_d;

   logic signed [COEF_W-1:0] b_q  [ORDER+1];  // b_0 .. b_ORDER
   logic signed [COEF_W-1:0] a_q  [ORDER];    // a_1 .. a_ORDER at index k-1
   logic signed [DATA_W-1:0] xh_q [ORDER+1];  // x0 (current) .. x_ORDER
   logic signed [DATA_W-1:0] yh_q [ORDER];    // y1 .. y_ORDER at index k-1
   logic signed [ACC_W-1:0]  acc_q;
   logic [TapW-1:0]          tap_q;
   logic signed [DATA_W-1:0] y_q;
   logic                     out_valid_q;
   logic                     ovf_q;

   logic signed [COEF_W-1:0] mac_coef;
   logic signed [DATA_W-1:0] mac_data;
   logic signed [ProdW-1:0]  prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_rnd;
   logic signed [ACC_W-1:0]  r;
   logic                     ovf_c;
   logic signed [DATA_W-1:0] result;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StMac;
            StMac:   if (tap_q == TapW'(NumTaps - 1)) state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      bus.in_ready = (state_q == StIdle) && !bus.clear;
   end

   // ---------------------------------------------------------------- MAC operand select
   // Taps 0..ORDER walk the b bank over x0..x_ORDER, taps ORDER+1..2*ORDER the a bank over y1..
   always_comb begin
      mac_coef = '0;
      mac_data = '0;
      for (int k = 0; k <= int'(ORDER); k++) begin
         if (tap_q == TapW'(k)) begin
            mac_coef = b_q[k];
            mac_data = xh_q[k];
         end
      end
      for (int k = 1; k <= int'(ORDER); k++) begin
         if (tap_q == TapW'(int'(ORDER) + k)) begin
            mac_coef = a_q[k-1];
            mac_data = yh_q[k-1];
         end
      end
   end

   assign prod     = mac_coef * mac_data;
   assign prod_ext = {{(ACC_W - ProdW){prod[ProdW-1]}}, prod};

   // ---------------------------------------------------------------- round / clamp
   assign acc_rnd = acc_q + RoundHalf;
   assign r       = acc_rnd >>> COEF_FRAC;
   assign ovf_c   = (r > MaxVal) || (r < MinVal);

   always_comb begin
      result = r[DATA_W-1:0];
      if (ovf_c && bus.sat_en) begin
         result = (r > MaxVal) ? MaxVal[DATA_W-1:0] : MinVal[DATA_W-1:0];
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k <= int'(ORDER); k++) begin
            b_q[k]  <= (k == 0) ? CoefOne : '0;
            xh_q[k] <= '0;
         end
         for (int k = 0; k < int'(ORDER); k++) begin
            a_q[k]  <= (k == 0) ? CoefOne : '0;
            yh_q[k] <= '0;
         end
         acc_q       <= '0;
         tap_q       <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (bus.clear) begin
         // Histories and result go to zero; coefficients survive
         for (int k = 0; k <= int'(ORDER); k++) xh_q[k] <= '0;
         for (int k = 0; k < int'(ORDER); k++) yh_q[k] <= '0;
         acc_q       <= '0;
         tap_q       <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  xh_q[0] <= bus.x;
                  acc_q   <= '0;
                  tap_q   <= '0;
               end
               // Writes only land here so a sample never sees a mixed coefficient set
               if (bus.coef_we) begin
                  if (!bus.coef_sel) begin
                     for (int k = 0; k <= int'(ORDER); k++) begin
                        if (bus.coef_addr == 3'(k)) b_q[k] <= bus.coef_data;
                     end
                  end else begin
                     for (int k = 1; k <= int'(ORDER); k++) begin
                        if (bus.coef_addr == 3'(k)) a_q[k-1] <= bus.coef_data;
                     end
                  end
               end
            end
            StMac: begin
               acc_q <= acc_q + prod_ext;
               tap_q <= tap_q + 1'b1;
            end
            StOut: begin
               y_q         <= result;
               out_valid_q <= 1'b1;
               ovf_q       <= ovf_c;
               for (int k = int'(ORDER); k >= 1; k--) xh_q[k] <= xh_q[k-1];
               for (int k = int'(ORDER) - 1; k >= 1; k--) yh_q[k] <= yh_q[k-1];
               // Feedback uses the post-saturation/wrap value, same as what left the block
               yh_q[0] <= result;
            end
            default: ;
         endcase
      end
   end

   assign bus.y         = y_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_diff_eq_filter.sv
// tb_diff_eq_filter
// Directed vectors for diff_eq_filter (ORDER=2, DATA_W=8, COEF_FRAC=6). Stimulus pushes the
// expected {ovf, y} into a queue; a monitor pops and compares on every out_valid.
module tb_diff_eq_filter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   diff_eq_filter_if #(.DATA_W(8), .COEF_W(8)) bus ();

   diff_eq_filter #(
      .DATA_W   (8),
      .COEF_W   (8),
      .COEF_FRAC(6),
      .ORDER    (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (!reset && bus.out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: got y=%0d ovf=%0b, required no output",
                     bus.y, bus.ovf);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.y !== mon_e[7:0] || bus.ovf !== mon_e[8]) begin
               errors++;
               $display("FAIL sample: got y=%0d ovf=%0b, required y=%0d ovf=%0b",
                        bus.y, bus.ovf, $signed(mon_e[7:0]), mon_e[8]);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
               errors++;
               $display("FAIL ready_with_out_valid: got %0b, required 1", bus.in_ready);
            end
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic idle_bus();
      bus.x = '0; bus.in_valid = 0; bus.sat_en = 0; bus.clear = 0;
      bus.coef_we = 0; bus.coef_sel = 0; bus.coef_addr = '0; bus.coef_data = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      check("reset_in_ready", int'(bus.in_ready), 1);
      check("reset_y", int'(bus.y), 0);
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_ovf", int'(bus.ovf), 0);
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready_timeout"}, int'(bus.in_ready), 1);
   endtask

   task automatic send(input int xv, input int yexp, input bit oexp);
      wait_ready("send");
      bus.x = 8'(xv);
      bus.in_valid = 1'b1;
      exp_q.push_back({oexp, 8'(yexp)});
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic write_coef(input bit sel, input int addr, input int data);
      wait_ready("coef");
      bus.coef_we = 1'b1; bus.coef_sel = sel; bus.coef_addr = 3'(addr);
      bus.coef_data = 8'(data);
      @(posedge clk);
      #1 bus.coef_we = 1'b0;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int n;
      int t;
      int last;
      idle_bus();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      do_reset();

      // Legacy accumulator behaviour
      send(1, 1, 0); send(2, 3, 0); send(3, 6, 0);
      drain();

      // Saturation and wrap
      do_reset();
      bus.sat_en = 1'b1;
      send(100, 100, 0); send(100, 127, 1);
      drain();
      do_reset();
      bus.sat_en = 1'b0;
      send(100, 100, 0); send(100, -56, 1);
      drain();
      do_reset();
      bus.sat_en = 1'b1;
      send(-100, -100, 0); send(-100, -128, 1);
      drain();
      bus.sat_en = 1'b0;

      // Half-weight FIR with rounding, then clear
      do_reset();
      write_coef(0, 0, 32); write_coef(0, 1, 32); write_coef(1, 1, 0);
      send(10, 5, 0); send(20, 15, 0); send(1, 11, 0);
      drain();
      @(negedge clk);
      bus.clear = 1'b1;
      @(posedge clk);
      #1 bus.clear = 1'b0;
      check("clear_y_zero", int'(bus.y), 0);
      send(1, 1, 0);
      drain();

      // Second-order feedback: y[n] = x[n] + y[n-2]
      do_reset();
      write_coef(1, 1, 0); write_coef(1, 2, 64);
      send(1, 1, 0); send(2, 2, 0); send(3, 4, 0); send(4, 6, 0);
      drain();

      // in_valid held high: acceptance every 7 cycles
      do_reset();
      bus.x = 8'd1;
      bus.in_valid = 1'b1;
      last = 0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("stream_ready_timeout", int'(bus.in_ready), 1);
         t = cyc;
         if (i > 0) check("accept_period", t - last, 7);
         last = t;
         exp_q.push_back({1'b0, 8'((i + 1) * (i + 2) / 2)});
         @(posedge clk);
         #1 bus.x = 8'(i + 2);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      drain();

      // clear during MAC aborts the sample (history y1=10 must also vanish)
      wait_ready("abort");
      bus.x = 8'd9;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      bus.clear = 1'b1;
      @(posedge clk);
      #1 bus.clear = 1'b0;
      #1 check("abort_in_ready", int'(bus.in_ready), 1);
      check("abort_y_zero", int'(bus.y), 0);
      repeat (10) @(negedge clk);
      send(5, 5, 0);
      drain();

      // clear with in_valid in the same cycle: sample rejected
      @(negedge clk);
      bus.clear = 1'b1; bus.in_valid = 1'b1; bus.x = 8'd7;
      @(posedge clk);
      #1 bus.clear = 1'b0; bus.in_valid = 1'b0;
      #1 check("clear_blocks_accept", int'(bus.in_ready), 1);
      repeat (12) @(negedge clk);
      send(2, 2, 0);
      drain();

      // Ignored coefficient writes
      do_reset();
      wait_ready("mac_write");
      bus.x = 8'd1;
      bus.in_valid = 1'b1;
      exp_q.push_back({1'b0, 8'd1});
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      bus.coef_we = 1'b1; bus.coef_sel = 1'b0; bus.coef_addr = 3'd0; bus.coef_data = 8'd0;
      @(posedge clk);
      #1 bus.coef_we = 1'b0;
      drain();
      write_coef(1, 0, 0);
      write_coef(0, 5, 64);
      send(2, 3, 0); send(4, 7, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
